// File: rtl/arbitro_pkg.sv
// Shared types for the data-memory arbiter: FSM states, return port and the
// read-return tag that travels alongside each memory read.
package arbitro_pkg;

   typedef enum logic [1:0] {
      LIBRE,
      CPU_ACC,
      VID_RAF
   } estado_t;

   typedef enum logic {
      P_CPU,
      P_VID
   } puerto_t;

   typedef struct packed {
      logic    valid;
      puerto_t port;
      logic    last;
   } tag_t;

   localparam tag_t TAG_NULO = '{valid: 1'b0, port: P_CPU, last: 1'b0};

endpackage

// File: rtl/linea_retardo_tag.sv
// RD_LAT-deep shift register of read-return tags, aligned with the memory read latency.
// tagSig exposes the tag that will reach tagOut on the next cycle.
module linea_retardo_tag
   import arbitro_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t tagIn,
   output tag_t tagOut,
   output tag_t tagSig
);

   tag_t etapa [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            etapa[i] <= TAG_NULO;
         end
      end else begin
         etapa[0] <= tagIn;
         for (int i = 1; i < RD_LAT; i++) begin
            etapa[i] <= etapa[i-1];
         end
      end
   end

   assign tagOut = etapa[RD_LAT-1];

   if (RD_LAT == 1) begin : gen_sig_directo
      assign tagSig = tagIn;
   end else begin : gen_sig_etapa
      assign tagSig = etapa[RD_LAT-2];
   end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Shares the single-port data memory between CPU load/store and video burst reads.
// Fixed CPU priority with a video anti-starvation counter; reads return via a tag pipeline.
module arbitro_memoria_datos
   import arbitro_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned MAX_WAIT  = 8,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cpuReq,
   input  logic                         cpuWr,
   input  logic [ADDR_W-1:0]            cpuAddr,
   input  logic [DATA_W-1:0]            cpuDatoW,
   output logic                         cpuGnt,
   output logic                         cpuValid,
   output logic [DATA_W-1:0]            cpuDatoR,
   input  logic                         vidReq,
   input  logic [ADDR_W-1:0]            vidAddr,
   input  logic [$clog2(MAX_BURST)-1:0] vidLen,
   output logic                         vidGnt,
   output logic                         vidValid,
   output logic [DATA_W-1:0]            vidDatoR,
   output logic                         vidDone,
   output logic                         memWr,
   output logic [ADDR_W-1:0]            memAddr,
   output logic [DATA_W-1:0]            memDatoW,
   input  logic [DATA_W-1:0]            memDatoR
);

   localparam int unsigned LEN_W  = $clog2(MAX_BURST);
   localparam int unsigned BEAT_W = LEN_W + 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   estado_t             estadoQ, estadoD;
   logic [BEAT_W-1:0]   beatsQ, beatsD;
   logic [WAIT_W-1:0]   waitCntQ, waitCntD;
   logic [ADDR_W-1:0]   memAddrQ, memAddrD;
   logic [DATA_W-1:0]   memDatoWQ, memDatoWD;
   logic                memWrQ, memWrD;

   logic ultimoBeat, decide, forzarVid, cpuApto, gntCpu, gntVid, cpuRet;
   tag_t tagIn, tagOut, tagSig;

   always_comb begin
      ultimoBeat = (estadoQ == VID_RAF) && (beatsQ == BEAT_W'(1));
      decide     = (estadoQ != VID_RAF) || ultimoBeat;
      forzarVid  = vidReq && (waitCntQ >= WAIT_W'(MAX_WAIT));
      // A write completes on its issue cycle; hold it off if a read return lands then too.
      cpuApto    = cpuReq && !(cpuWr && tagSig.valid);
      gntVid     = rst_n && decide && vidReq && (forzarVid || !cpuApto);
      gntCpu     = rst_n && decide && cpuApto && !gntVid;
   end

   always_comb begin
      estadoD   = estadoQ;
      beatsD    = beatsQ;
      memAddrD  = memAddrQ;
      memDatoWD = memDatoWQ;
      memWrD    = 1'b0;
      if (gntCpu) begin
         estadoD   = CPU_ACC;
         memAddrD  = cpuAddr;
         memDatoWD = cpuDatoW;
         memWrD    = cpuWr;
      end else if (gntVid) begin
         estadoD  = VID_RAF;
         memAddrD = {vidAddr[ADDR_W-1:2], 2'b00};
         beatsD   = (vidLen == '0) ? BEAT_W'(MAX_BURST) : {1'b0, vidLen};
      end else if ((estadoQ == VID_RAF) && !ultimoBeat) begin
         memAddrD = memAddrQ + ADDR_W'(4);
         beatsD   = beatsQ - BEAT_W'(1);
      end else begin
         estadoD = LIBRE;
      end

      waitCntD = waitCntQ;
      if (!vidReq || gntVid) begin
         waitCntD = '0;
      end else if (waitCntQ < WAIT_W'(MAX_WAIT)) begin
         waitCntD = waitCntQ + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estadoQ   <= LIBRE;
         beatsQ    <= '0;
         waitCntQ  <= '0;
         memAddrQ  <= '0;
         memDatoWQ <= '0;
         memWrQ    <= 1'b0;
      end else begin
         estadoQ   <= estadoD;
         beatsQ    <= beatsD;
         waitCntQ  <= waitCntD;
         memAddrQ  <= memAddrD;
         memDatoWQ <= memDatoWD;
         memWrQ    <= memWrD;
      end
   end

   always_comb begin
      tagIn       = TAG_NULO;
      tagIn.valid = ((estadoQ == CPU_ACC) && !memWrQ) || (estadoQ == VID_RAF);
      tagIn.port  = (estadoQ == VID_RAF) ? P_VID : P_CPU;
      tagIn.last  = ultimoBeat;
   end

   linea_retardo_tag #(
      .RD_LAT (RD_LAT)
   ) u_linea (
      .clk    (clk),
      .rst_n  (rst_n),
      .tagIn  (tagIn),
      .tagOut (tagOut),
      .tagSig (tagSig)
   );

   always_comb begin
      cpuRet   = tagOut.valid && (tagOut.port == P_CPU);
      vidValid = tagOut.valid && (tagOut.port == P_VID);
      vidDone  = vidValid && tagOut.last;
      cpuValid = cpuRet || ((estadoQ == CPU_ACC) && memWrQ);
      cpuDatoR = cpuRet ? memDatoR : '0;
      vidDatoR = vidValid ? memDatoR : '0;
      cpuGnt   = gntCpu;
      vidGnt   = gntVid;
      memWr    = memWrQ;
      memAddr  = memAddrQ;
      memDatoW = memDatoWQ;
   end

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed bench for arbitro_memoria_datos with RD_LAT=1 and a memory model
// that returns the inverted address one cycle after it is presented.
module tb_arbitro_memoria_datos;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpuReq, cpuWr, cpuGnt, cpuValid;
   logic [31:0] cpuAddr, cpuDatoW, cpuDatoR;
   logic        vidReq, vidGnt, vidValid, vidDone;
   logic [31:0] vidAddr, vidDatoR;
   logic [3:0]  vidLen;
   logic        memWr;
   logic [31:0] memAddr, memDatoW, memDatoR;

   int nTests = 0;
   int nFail  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) memDatoR <= ~memAddr;

   arbitro_memoria_datos dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpuReq   (cpuReq),
      .cpuWr    (cpuWr),
      .cpuAddr  (cpuAddr),
      .cpuDatoW (cpuDatoW),
      .cpuGnt   (cpuGnt),
      .cpuValid (cpuValid),
      .cpuDatoR (cpuDatoR),
      .vidReq   (vidReq),
      .vidAddr  (vidAddr),
      .vidLen   (vidLen),
      .vidGnt   (vidGnt),
      .vidValid (vidValid),
      .vidDatoR (vidDatoR),
      .vidDone  (vidDone),
      .memWr    (memWr),
      .memAddr  (memAddr),
      .memDatoW (memDatoW),
      .memDatoR (memDatoR)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      nTests++;
      if (obs !== esp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   function automatic logic [31:0] inv(input logic [31:0] a);
      return ~a;
   endfunction

   function automatic logic [31:0] beatAddr(input logic [31:0] base, input int k);
      logic [31:0] r;
      r = {base[31:2], 2'b00} + 32'(4 * k);
      return r;
   endfunction

   // Issue one burst and check every issued address and returned beat.
   task automatic rafaga(input logic [31:0] base, input int n);
      @(negedge clk);
      vidReq  = 1'b1;
      vidAddr = base;
      vidLen  = n[3:0];
      #1 chk("vidGnt", vidGnt, 1);
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clk);
         vidReq = 1'b0;
         #1;
         if (k <= n) chk("vidAddr", memAddr, beatAddr(base, k - 1));
         chk("vidValid", vidValid, k >= 2);
         chk("vidDone", vidDone, k == n + 1);
         if (k >= 2) chk("vidDato", vidDatoR, inv(beatAddr(base, k - 2)));
      end
      @(negedge clk);
      #1 chk("vidValidEnd", vidValid, 0);
   endtask

   initial begin
      int cnt;
      rst_n    = 1'b0;
      cpuReq   = 1'b0;
      cpuWr    = 1'b0;
      cpuAddr  = '0;
      cpuDatoW = '0;
      vidReq   = 1'b0;
      vidAddr  = '0;
      vidLen   = '0;
      #3;
      chk("rstGnt", {cpuGnt, vidGnt}, 0);
      chk("rstValid", {cpuValid, vidValid, vidDone}, 0);
      chk("rstMem", {memWr, memAddr, memDatoW}, 0);
      chk("rstDato", {cpuDatoR, vidDatoR}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // CPU read
      @(negedge clk);
      cpuReq  = 1'b1;
      cpuWr   = 1'b0;
      cpuAddr = 32'h40;
      #1 chk("rdGnt", cpuGnt, 1);
      @(negedge clk);
      cpuReq = 1'b0;
      #1;
      chk("rdAddr", memAddr, 32'h40);
      chk("rdMemWr", memWr, 0);
      chk("rdValEarly", cpuValid, 0);
      @(negedge clk);
      #1;
      chk("rdValid", cpuValid, 1);
      chk("rdDato", cpuDatoR, inv(32'h40));
      chk("rdVidValid", vidValid, 0);
      @(negedge clk);
      #1 chk("rdValidOff", cpuValid, 0);

      // CPU write
      @(negedge clk);
      cpuReq   = 1'b1;
      cpuWr    = 1'b1;
      cpuAddr  = 32'h80;
      cpuDatoW = 32'hDEADBEEF;
      #1 chk("wrGnt", cpuGnt, 1);
      @(negedge clk);
      cpuReq = 1'b0;
      #1;
      chk("wrMemWr", memWr, 1);
      chk("wrAddr", memAddr, 32'h80);
      chk("wrDato", memDatoW, 32'hDEADBEEF);
      chk("wrValid", cpuValid, 1);
      @(negedge clk);
      #1;
      chk("wrMemWrOff", memWr, 0);
      chk("wrValidOff", cpuValid, 0);
      @(negedge clk);
      #1;
      chk("wrNoReturn", cpuValid, 0);
      chk("wrAddrHold", memAddr, 32'h80);

      // Bursts: plain, address wrap, len 0 = MAX_BURST with low bits ignored
      rafaga(32'h100, 4);
      rafaga(32'hFFFFFFF8, 4);
      rafaga(32'h303, 16);

      // Simultaneous requests: CPU wins 8 decisions, video forced on the 9th
      @(negedge clk);
      cpuReq  = 1'b1;
      cpuWr   = 1'b0;
      cpuAddr = 32'h500;
      vidReq  = 1'b1;
      vidAddr = 32'h600;
      vidLen  = 4'd1;
      for (int d = 0; d < 9; d++) begin
         #1;
         chk("hamCpuGnt", cpuGnt, d < 8);
         chk("hamVidGnt", vidGnt, d == 8);
         @(negedge clk);
      end
      cpuReq = 1'b0;
      vidReq = 1'b0;
      #1 chk("hamVidAddr", memAddr, 32'h600);
      @(negedge clk);
      #1;
      chk("hamVidDone", {vidValid, vidDone, cpuValid}, 3'b110);
      repeat (2) @(negedge clk);

      // Reset in the middle of a burst
      @(negedge clk);
      vidReq  = 1'b1;
      vidAddr = 32'h200;
      vidLen  = 4'd8;
      #1 chk("abGnt", vidGnt, 1);
      @(negedge clk);
      vidReq = 1'b0;
      #1 chk("abAddr0", memAddr, 32'h200);
      @(negedge clk);
      #1;
      chk("abAddr1", memAddr, 32'h204);
      chk("abValid", vidValid, 1);
      rst_n = 1'b0;
      #1;
      chk("abRstMem", {memWr, memAddr}, 0);
      chk("abRstValid", {vidValid, vidDone, cpuValid}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         #1 if (vidValid || vidDone) cnt++;
      end
      chk("abNoValid", cnt, 0);
      chk("abAddrIdle", memAddr, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
